// File: rtl/tone_pkg.sv
// tone_pkg: shared widths, state encoding and default amplitude for the tone generator.
package tone_pkg;
    localparam int PERIOD_W = 32;
    localparam int AUDIO_W = 16;
    localparam int MIN_PERIOD = 2;
    localparam logic signed [AUDIO_W-1:0] DEF_AMPLITUDE = 16'sd8192;
    typedef enum logic [1:0] {IDLE, PLAY, PENDING} state_t;
endpackage

// File: rtl/tone_phase_counter.sv
// tone_phase_counter: period counter with clamping, wrap detection and registered square-wave level.
module tone_phase_counter #(
    parameter int W = tone_pkg::PERIOD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_stop,
    input  logic         i_run,
    input  logic [W-1:0] i_period,
    output logic         o_wrap,
    output logic         o_tone
);
    import tone_pkg::*;
    logic [W-1:0] r_period, r_cnt, w_clamped, w_cnt_next;
    logic         r_tone;
    assign w_clamped  = (i_period < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : i_period;
    assign o_wrap     = r_cnt == r_period - W'(1);
    assign w_cnt_next = o_wrap ? '0 : r_cnt + W'(1);
    assign o_tone     = r_tone;
    // Level is computed from the next count so it lines up with the registered counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_tone   <= 1'b0;
        end else if (i_load) begin
            r_period <= w_clamped;
            r_cnt    <= '0;
            r_tone   <= 1'b1;
        end else if (i_stop) begin
            r_cnt    <= '0;
            r_tone   <= 1'b0;
        end else if (i_run) begin
            r_cnt    <= w_cnt_next;
            r_tone   <= w_cnt_next < (r_period >> 1);
        end
    end
endmodule

// File: rtl/tone_generator.sv
// tone_generator: period-driven square-wave tone with boundary-aligned note changes and PCM samples.
module tone_generator #(
    parameter int PERIOD_W = tone_pkg::PERIOD_W,
    parameter int AUDIO_W = tone_pkg::AUDIO_W,
    parameter logic signed [AUDIO_W-1:0] AMPLITUDE = tone_pkg::DEF_AMPLITUDE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PERIOD_W-1:0]        div_count,
    input  logic                       div_valid,
    output logic                       div_ready,
    input  logic                       sample_tick,
    output logic                       tone_out,
    output logic signed [AUDIO_W-1:0]  audio_out,
    output logic                       audio_valid,
    output logic                       active
);
    import tone_pkg::*;
    state_t                     r_state;
    logic [PERIOD_W-1:0]        r_pend, w_load_period;
    logic                       r_ready, r_active, r_audio_valid;
    logic signed [AUDIO_W-1:0]  r_audio;
    logic                       w_xfer, w_wrap, w_tone, w_load, w_stop, w_apply;
    assign w_xfer        = div_valid && r_ready;
    assign w_apply       = r_state == PENDING && w_wrap;
    assign w_load        = (r_state == IDLE && w_xfer && div_count != '0) || (w_apply && r_pend != '0);
    assign w_stop        = w_apply && r_pend == '0;
    assign w_load_period = r_state == IDLE ? div_count : r_pend;
    tone_phase_counter #(.W(PERIOD_W)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_stop   (w_stop),
        .i_run    (r_state != IDLE),
        .i_period (w_load_period),
        .o_wrap   (w_wrap),
        .o_tone   (w_tone)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pend   <= '0;
            r_ready  <= 1'b1;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_xfer && div_count != '0) begin
                    r_state  <= PLAY;
                    r_active <= 1'b1;
                end
                PLAY: if (w_xfer) begin
                    r_pend  <= div_count;
                    r_state <= PENDING;
                    r_ready <= 1'b0;
                end
                PENDING: if (w_wrap) begin
                    r_ready  <= 1'b1;
                    r_state  <= r_pend != '0 ? PLAY : IDLE;
                    r_active <= r_pend != '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Samples use the level present on the tick cycle, before any same-cycle update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_audio       <= '0;
            r_audio_valid <= 1'b0;
        end else begin
            r_audio_valid <= sample_tick;
            if (sample_tick)
                r_audio <= !r_active ? '0 : (w_tone ? AMPLITUDE : -AMPLITUDE);
        end
    end
    assign div_ready   = r_ready;
    assign active      = r_active;
    assign tone_out    = w_tone;
    assign audio_out   = r_audio;
    assign audio_valid = r_audio_valid;
endmodule
